// File: rtl/cache_mem_arbiter.sv
// Arbiter sharing one 32-bit burst memory port between the icache (reads)
// and the dcache (reads and buffered writes); one transaction in flight.
module cache_mem_arbiter #(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ic_rd_req,
  input  logic [2:0]               ic_rd_type,
  input  logic [31:0]              ic_rd_addr,
  output logic                     ic_rd_rdy,
  output logic                     ic_ret_valid,
  output logic                     ic_ret_last,
  output logic [31:0]              ic_ret_data,
  input  logic                     dc_rd_req,
  input  logic [2:0]               dc_rd_type,
  input  logic [31:0]              dc_rd_addr,
  output logic                     dc_rd_rdy,
  output logic                     dc_ret_valid,
  output logic                     dc_ret_last,
  output logic [31:0]              dc_ret_data,
  input  logic                     dc_wr_req,
  input  logic [2:0]               dc_wr_type,
  input  logic [31:0]              dc_wr_addr,
  input  logic [3:0]               dc_wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] dc_wr_data,
  output logic                     dc_wr_rdy,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [1:0]               mem_len,
  output logic [1:0]               mem_size,
  output logic [3:0]               mem_strb,
  input  logic                     mem_ack,
  output logic                     mem_wvalid,
  output logic [31:0]              mem_wdata,
  output logic                     mem_wlast,
  input  logic                     mem_wready,
  input  logic                     mem_rvalid,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_rlast,
  input  logic                     mem_bvalid,
  output logic                     err
);

  localparam int unsigned LINE_BITS = 32 * LINE_WORDS;
  localparam logic [2:0]  TYPE_LINE = 3'b100;
  localparam logic [1:0]  LINE_LEN  = 2'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;
  typedef enum logic [1:0] {P_DW, P_DR, P_IR} ptr_t;

  state_t               state;
  ptr_t                 ptr;
  logic                 run;
  logic                 owner_ic;
  logic                 is_line;
  logic [1:0]           lane;
  logic [1:0]           cnt;
  logic [LINE_BITS-1:0] wbuf;

  logic        rd_from_ic;
  logic        rd_req_sel;
  logic [2:0]  rd_type_sel;
  logic [31:0] rd_addr_sel;
  logic [1:0]  widx;

  function automatic ptr_t ptr_succ(input ptr_t p);
    case (p)
      P_DW:    return P_DR;
      P_DR:    return P_IR;
      default: return P_DW;
    endcase
  endfunction

  // Read requester selected by the token (only meaningful when ptr != DW)
  assign rd_from_ic  = (ptr == P_IR);
  assign rd_req_sel  = rd_from_ic ? ic_rd_req  : dc_rd_req;
  assign rd_type_sel = rd_from_ic ? ic_rd_type : dc_rd_type;
  assign rd_addr_sel = rd_from_ic ? ic_rd_addr : dc_rd_addr;

  // Ready strobes come only from registered state; run keeps them low the first cycle out of reset
  assign dc_wr_rdy = run && (state == IDLE) && (ptr == P_DW);
  assign dc_rd_rdy = run && (state == IDLE) && (ptr == P_DR);
  assign ic_rd_rdy = run && (state == IDLE) && (ptr == P_IR);

  // Address and write phases decoded from the state register
  assign mem_req    = (state == RADDR) || (state == WADDR);
  assign mem_we     = (state == WADDR);
  assign widx       = is_line ? cnt : lane;
  assign mem_wvalid = (state == WDATA);
  assign mem_wlast  = (state == WDATA) && (cnt == mem_len);
  assign mem_wdata  = (state == WDATA) ? wbuf[{widx, 5'b0} +: 32] : 32'h0;

  // Read beats are forwarded to the owner with no added latency
  assign ic_ret_valid = (state == RDATA) && owner_ic && mem_rvalid;
  assign ic_ret_last  = ic_ret_valid && mem_rlast;
  assign ic_ret_data  = ic_ret_valid ? mem_rdata : 32'h0;
  assign dc_ret_valid = (state == RDATA) && !owner_ic && mem_rvalid;
  assign dc_ret_last  = dc_ret_valid && mem_rlast;
  assign dc_ret_data  = dc_ret_valid ? mem_rdata : 32'h0;

  // Arbitration FSM, captured request registers and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= P_DW;
      run      <= 1'b0;
      owner_ic <= 1'b0;
      is_line  <= 1'b0;
      lane     <= 2'b0;
      cnt      <= 2'b0;
      wbuf     <= '0;
      mem_addr <= 32'h0;
      mem_len  <= 2'b0;
      mem_size <= 2'b0;
      mem_strb <= 4'h0;
      err      <= 1'b0;
    end else begin
      run <= 1'b1;
      if ((mem_rvalid && state != RDATA) || (mem_bvalid && state != WRESP))
        err <= 1'b1;
      case (state)
        IDLE: begin
          cnt <= 2'b0;
          if (run) begin
            ptr <= ptr_succ(ptr);
            if (ptr == P_DW) begin
              if (dc_wr_req) begin
                state    <= WADDR;
                wbuf     <= dc_wr_data;
                mem_size <= 2'b10;
                if (dc_wr_type == TYPE_LINE) begin
                  is_line  <= 1'b1;
                  lane     <= 2'b0;
                  mem_addr <= {dc_wr_addr[31:4], 4'b0};
                  mem_len  <= LINE_LEN;
                  mem_strb <= 4'hf;
                end else begin
                  is_line  <= 1'b0;
                  lane     <= dc_wr_addr[3:2];
                  mem_addr <= {dc_wr_addr[31:2], 2'b0};
                  mem_len  <= 2'b0;
                  mem_strb <= dc_wr_wstrb;
                end
              end
            end else if (rd_req_sel) begin
              state    <= RADDR;
              owner_ic <= rd_from_ic;
              mem_strb <= 4'h0;
              if (rd_type_sel == TYPE_LINE) begin
                mem_addr <= {rd_addr_sel[31:4], 4'b0};
                mem_len  <= LINE_LEN;
                mem_size <= 2'b10;
              end else begin
                mem_addr <= rd_addr_sel;
                mem_len  <= 2'b0;
                mem_size <= rd_type_sel[1:0];
              end
            end
          end
        end
        RADDR: if (mem_ack) state <= RDATA;
        RDATA: begin
          if (mem_rvalid) begin
            if (mem_rlast) begin
              if (cnt != mem_len) err <= 1'b1;
              cnt   <= 2'b0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        WADDR: if (mem_ack) state <= WDATA;
        WDATA: begin
          if (mem_wready) begin
            if (cnt == mem_len) begin
              cnt   <= 2'b0;
              state <= WRESP;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        WRESP: if (mem_bvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: read decode table, word and line
// writes, write-before-read ordering, token rotation, rlast error and async reset.
module tb_cache_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         ic_rd_req, ic_rd_rdy, ic_ret_valid, ic_ret_last;
  logic [2:0]   ic_rd_type;
  logic [31:0]  ic_rd_addr, ic_ret_data;
  logic         dc_rd_req, dc_rd_rdy, dc_ret_valid, dc_ret_last;
  logic [2:0]   dc_rd_type;
  logic [31:0]  dc_rd_addr, dc_ret_data;
  logic         dc_wr_req, dc_wr_rdy;
  logic [2:0]   dc_wr_type;
  logic [31:0]  dc_wr_addr;
  logic [3:0]   dc_wr_wstrb;
  logic [127:0] dc_wr_data;
  logic         mem_req, mem_we, mem_ack, mem_wvalid, mem_wlast, mem_wready;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [1:0]   mem_len, mem_size;
  logic [3:0]   mem_strb;
  logic         mem_rvalid, mem_rlast, mem_bvalid, err;

  cache_mem_arbiter #(.LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr), .dc_wr_wstrb(dc_wr_wstrb),
    .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len), .mem_size(mem_size),
    .mem_strb(mem_strb), .mem_ack(mem_ack), .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata),
    .mem_wlast(mem_wlast), .mem_wready(mem_wready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rlast(mem_rlast), .mem_bvalid(mem_bvalid), .err(err)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] rq[$];
  logic [31:0] wq[$];
  int grant_q[$];

  typedef struct {
    bit          ic;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] exp_addr;
    logic [1:0]  exp_len;
    logic [1:0]  exp_size;
  } rd_vec_t;

  rd_vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic do_read(input bit ic, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] exp_addr, input logic [1:0] exp_len,
                         input logic [1:0] exp_size, input int last_beat);
    int n;
    logic [31:0] d;
    logic [31:0] e;
    if (ic) begin ic_rd_req = 1'b1; ic_rd_type = typ; ic_rd_addr = addr; end
    else    begin dc_rd_req = 1'b1; dc_rd_type = typ; dc_rd_addr = addr; end
    #1;
    n = 0;
    while (!(ic ? ic_rd_rdy : dc_rd_rdy) && n < 8) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 8) begin
      n_chk++; n_fail++;
      $display("FAIL rd_grant_timeout: got no rdy expected rdy within 8 cycles");
    end
    @(negedge clk); #1;
    ic_rd_req = 1'b0;
    dc_rd_req = 1'b0;
    chk("rd_mem_req", 32'(mem_req), 32'd1);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    chk("rd_mem_addr", mem_addr, exp_addr);
    chk("rd_mem_len", 32'(mem_len), 32'(exp_len));
    chk("rd_mem_size", 32'(mem_size), 32'(exp_size));
    mem_ack = 1'b1;
    @(negedge clk); #1;
    mem_ack = 1'b0;
    chk("rd_busy_rdy", 32'({ic_rd_rdy, dc_rd_rdy, dc_wr_rdy}), 32'd0);
    for (int b = 0; b <= last_beat; b++) begin
      d = $urandom;
      rq.push_back(d);
      mem_rvalid = 1'b1;
      mem_rdata  = d;
      mem_rlast  = (b == last_beat);
      #1;
      e = rq.pop_front();
      chk("ret_valid_owner", 32'(ic ? ic_ret_valid : dc_ret_valid), 32'd1);
      chk("ret_valid_other", 32'(ic ? dc_ret_valid : ic_ret_valid), 32'd0);
      chk("ret_data", ic ? ic_ret_data : dc_ret_data, e);
      chk("ret_last", 32'(ic ? ic_ret_last : dc_ret_last), 32'(b == last_beat));
      @(negedge clk); #1;
    end
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
  endtask

  task automatic do_write(input bit line, input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [127:0] data, input logic [31:0] exp_addr,
                          input logic [1:0] exp_len, input logic [3:0] exp_strb, input bit stall);
    int n;
    logic [127:0] sh;
    if (line) begin
      for (int i = 0; i < 4; i++) begin sh = data >> (32 * i); wq.push_back(sh[31:0]); end
    end else begin
      sh = data >> (32 * int'(addr[3:2]));
      wq.push_back(sh[31:0]);
    end
    dc_wr_req = 1'b1; dc_wr_type = line ? 3'b100 : 3'b010;
    dc_wr_addr = addr; dc_wr_wstrb = wstrb; dc_wr_data = data;
    #1;
    n = 0;
    while (!dc_wr_rdy && n < 8) begin @(negedge clk); #1; n++; end
    if (n >= 8) begin
      n_chk++; n_fail++;
      $display("FAIL wr_grant_timeout: got no rdy expected rdy within 8 cycles");
    end
    @(negedge clk); #1;
    dc_wr_req = 1'b0;
    dc_wr_data = '1;
    chk("wr_mem_req", 32'(mem_req), 32'd1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_addr", mem_addr, exp_addr);
    chk("wr_mem_len", 32'(mem_len), 32'(exp_len));
    chk("wr_mem_strb", 32'(mem_strb), 32'(exp_strb));
    chk("wr_mem_size", 32'(mem_size), 32'd2);
    mem_ack = 1'b1;
    @(negedge clk); #1;
    mem_ack = 1'b0;
    n = 0;
    while (wq.size() > 0 && n < 20) begin
      mem_wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("wvalid", 32'(mem_wvalid), 32'd1);
      chk("wdata", mem_wdata, wq[0]);
      chk("wlast", 32'(mem_wlast), 32'(wq.size() == 1));
      if (mem_wready) void'(wq.pop_front());
      @(negedge clk); #1;
      n++;
    end
    if (wq.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL wr_beats_timeout: got %0d beats left expected 0", wq.size());
      wq.delete();
    end
    mem_wready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("wresp_wvalid", 32'(mem_wvalid), 32'd0);
      chk("wresp_req", 32'(mem_req), 32'd0);
      chk("wresp_rdy", 32'({ic_rd_rdy, dc_rd_rdy, dc_wr_rdy}), 32'd0);
      @(negedge clk); #1;
    end
    mem_bvalid = 1'b1;
    @(negedge clk); #1;
    mem_bvalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g;
    bit rpend;
    bit bpend;
    tbl[0] = '{1'b1, 3'b100, 32'h1C000104, 32'h1C000100, 2'd3, 2'd2};
    tbl[1] = '{1'b0, 3'b000, 32'h00001003, 32'h00001003, 2'd0, 2'd0};
    tbl[2] = '{1'b1, 3'b001, 32'h00002002, 32'h00002002, 2'd0, 2'd1};
    tbl[3] = '{1'b0, 3'b010, 32'h80000004, 32'h80000004, 2'd0, 2'd2};
    tbl[4] = '{1'b0, 3'b100, 32'h1234567C, 32'h12345670, 2'd3, 2'd2};

    ic_rd_req = 0; ic_rd_type = 0; ic_rd_addr = 0;
    dc_rd_req = 0; dc_rd_type = 0; dc_rd_addr = 0;
    dc_wr_req = 0; dc_wr_type = 0; dc_wr_addr = 0; dc_wr_wstrb = 0; dc_wr_data = 0;
    mem_ack = 0; mem_wready = 0; mem_rvalid = 0; mem_rdata = 0; mem_rlast = 0; mem_bvalid = 0;

    // Reset values and token start
    reset = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_rdy", 32'({ic_rd_rdy, dc_rd_rdy, dc_wr_rdy}), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_rdy", 32'({ic_rd_rdy, dc_rd_rdy, dc_wr_rdy}), 32'd0);
    @(negedge clk); #1;
    chk("tok_dw", 32'({ic_rd_rdy, dc_rd_rdy, dc_wr_rdy}), 32'b001);
    @(negedge clk); #1;
    chk("tok_dr", 32'({ic_rd_rdy, dc_rd_rdy, dc_wr_rdy}), 32'b010);
    @(negedge clk); #1;
    chk("tok_ir", 32'({ic_rd_rdy, dc_rd_rdy, dc_wr_rdy}), 32'b100);

    // Read decode table
    for (int i = 0; i < 5; i++)
      do_read(tbl[i].ic, tbl[i].typ, tbl[i].addr, tbl[i].exp_addr, tbl[i].exp_len,
              tbl[i].exp_size, int'(tbl[i].exp_len));
    chk("err_clean", 32'(err), 32'd0);

    // Uncached word write, lane 2
    do_write(1'b0, 32'hBFAF8008, 4'b0011,
             {32'h44444444, 32'h0000ABCD, 32'h22222222, 32'h11111111},
             32'hBFAF8008, 2'd0, 4'b0011, 1'b0);

    // Line write with a dcache read raised in the same cycle
    n = 0;
    #1;
    while (!dc_wr_rdy && n < 8) begin @(negedge clk); #1; n++; end
    dc_rd_req = 1'b1; dc_rd_type = 3'b100; dc_rd_addr = 32'h50000020;
    do_write(1'b1, 32'h60000034, 4'b0000,
             {32'hD0D0D0D3, 32'hC0C0C0C2, 32'hB0B0B0B1, 32'hA0A0A0A0},
             32'h60000030, 2'd3, 4'hF, 1'b1);
    do_read(1'b0, 3'b100, 32'h50000020, 32'h50000020, 2'd3, 2'd2, 3);
    chk("err_after_wr", 32'(err), 32'd0);

    // Early rlast on the second beat of a line read
    do_read(1'b0, 3'b100, 32'h40000010, 32'h40000010, 2'd3, 2'd2, 1);
    chk("err_set", 32'(err), 32'd1);
    do_read(1'b1, 3'b010, 32'h00000040, 32'h00000040, 2'd0, 2'd2, 0);
    chk("err_sticky", 32'(err), 32'd1);

    // Asynchronous reset mid-RDATA
    ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h00007000;
    #1;
    n = 0;
    while (!ic_rd_rdy && n < 8) begin @(negedge clk); #1; n++; end
    @(negedge clk); #1;
    ic_rd_req = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk); #1;
    mem_ack = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0000; mem_rlast = 1'b0;
    #1;
    chk("pre_rst_ret", 32'(ic_ret_valid), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("arst_ret_valid", 32'(ic_ret_valid), 32'd0);
    chk("arst_ret_data", ic_ret_data, 32'd0);
    chk("arst_mem_req", 32'(mem_req), 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_mem_len", 32'(mem_len), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_rdy", 32'({ic_rd_rdy, dc_rd_rdy, dc_wr_rdy}), 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b0; mem_rdata = 0;
    @(negedge clk); #1;
    chk("restart_tok_dw", 32'({ic_rd_rdy, dc_rd_rdy, dc_wr_rdy}), 32'b001);
    @(negedge clk); #1;
    chk("restart_tok_dr", 32'({ic_rd_rdy, dc_rd_rdy, dc_wr_rdy}), 32'b010);
    chk("restart_err", 32'(err), 32'd0);

    // All requesters busy against a 1-cycle memory: grants rotate DW, DR, IR
    do_reset();
    for (int k = 0; k < 2; k++) begin grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(2); end
    dc_wr_req = 1'b1; dc_wr_type = 3'b010; dc_wr_addr = 32'h00003000; dc_wr_wstrb = 4'hF;
    dc_wr_data = 128'h0;
    dc_rd_req = 1'b1; dc_rd_type = 3'b010; dc_rd_addr = 32'h00001000;
    ic_rd_req = 1'b1; ic_rd_type = 3'b010; ic_rd_addr = 32'h00002000;
    mem_wready = 1'b1;
    rpend = 1'b0; bpend = 1'b0; g = 0;
    for (int c = 0; c < 80; c++) begin
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_bvalid = 1'b0;
      if (bpend) begin mem_bvalid = 1'b1; bpend = 1'b0; end
      else if (rpend) begin mem_rvalid = 1'b1; mem_rlast = 1'b1; mem_rdata = 32'(c); rpend = 1'b0; end
      if (mem_req) begin
        mem_ack = 1'b1;
        if (grant_q.size() > 0)
          chk("grant_order", mem_we ? 32'd0 : (mem_addr == 32'h00001000 ? 32'd1 : 32'd2),
              32'(grant_q.pop_front()));
        if (!mem_we) rpend = 1'b1;
        g++;
        if (g == 6) begin dc_wr_req = 1'b0; dc_rd_req = 1'b0; ic_rd_req = 1'b0; end
      end
      if (mem_wvalid && mem_wlast) bpend = 1'b1;
      @(negedge clk); #1;
      if (g >= 6 && !rpend && !bpend && !mem_rvalid && !mem_bvalid && !mem_ack) break;
    end
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_bvalid = 1'b0; mem_wready = 1'b0;
    chk("grants_done", 32'(grant_q.size()), 32'd0);
    chk("rot_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
